fixed_point_sse_accumulator: RTL and testbench

// - Sits directly downstream of the fixed-point subtractor. Consumes its signed Qm.Q difference words one by one.
// - Squares each difference with a sequential shift-add multiplier and accumulates a saturating sum of squared errors (SSE).
// - After FRAME_LEN samples, presents the frame's SSE on a valid/ready output.
// - Used for error/distance metrics between fixed-point vectors.

---
 rtl/fixed_point_pkg.sv | 32 +++
 rtl/fixed_point_sse_accumulator_if.sv | 24 ++
 rtl/fixed_point_seq_squarer.sv | 66 ++++++
 rtl/fixed_point_sse_accumulator.sv | 102 ++++++++++
 tb/tb_fixed_point_sse_accumulator.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fixed_point_pkg.sv
// Shared constants, FSM encoding and saturating-add helper for the fixed-point SSE datapath.
package fixed_point_pkg;

  localparam int Q_DEF = 8;
  localparam int N_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic        sat;
    logic [63:0] sum;
  } sat_res_t;

  // Unsigned add clamped to 2^w-1; operands are zero-extended into 64 bits, so w <= 64.
  function automatic sat_res_t sat_add(input logic [63:0] a, input logic [63:0] b,
                                       input int unsigned w);
    sat_res_t    r;
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    r.sat = (s > lim);
    r.sum = r.sat ? lim[63:0] : s[63:0];
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_sse_accumulator_if.sv
// Sample-in / SSE-out handshake bundle between the subtractor, this block and its consumer.
interface fixed_point_sse_accumulator_if #(
  parameter int N     = 16,
  parameter int ACC_W = 40
);
  logic [N-1:0]     diff_in;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [ACC_W-1:0] sse_out;
  logic             sse_sat;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output diff_in, in_valid, clear, out_ready,
    input  in_ready, sse_out, sse_sat, out_valid
  );

  modport slave (
    input  diff_in, in_valid, clear, out_ready,
    output in_ready, sse_out, sse_sat, out_valid
  );
endinterface

// File: rtl/fixed_point_seq_squarer.sv
// N-cycle LSB-first shift-add squarer; done pulses during the final step cycle.
module fixed_point_seq_squarer #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [N-1:0]   mag,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [2*N-1:0] prod_q,  prod_d;
  logic [N-1:0]   mplr_q,  mplr_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic           busy_q,  busy_d;

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (abort) begin
      prod_d = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (start) begin
      mcand_d = {{N{1'b0}}, mag};
      mplr_d  = mag;
      prod_d  = '0;
      cnt_d   = CW'(N);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (mplr_q[0]) prod_d = prod_q + mcand_q;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(1));
  assign product = prod_q;
endmodule

// File: rtl/fixed_point_sse_accumulator.sv
// Frame SSE engine: |diff| squared by a sequential squarer, truncated to Q, summed with saturation.
module fixed_point_sse_accumulator
  import fixed_point_pkg::*;
#(
  parameter int Q         = Q_DEF,
  parameter int N         = N_DEF,
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 40
) (
  input logic clk,
  input logic rst,
  fixed_point_sse_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic             sat_q,   sat_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             rdy_q;

  logic             sq_start, sq_abort, sq_busy, sq_done;
  logic [N-1:0]     mag;
  logic [2*N-1:0]   product;
  logic [2*N-1:0]   term;
  sat_res_t         add_r;

  // Two's-complement negate in N bits maps -2^(N-1) onto 2^(N-1) as an unsigned value.
  assign mag  = bus.diff_in[N-1] ? (~bus.diff_in + N'(1)) : bus.diff_in;
  assign term = product >> Q;
  assign add_r = sat_add(64'(acc_q), 64'(term), ACC_W);

  fixed_point_seq_squarer #(.N(N)) u_sq (
    .clk     (clk),
    .rst     (rst),
    .start   (sq_start),
    .abort   (sq_abort),
    .mag     (mag),
    .busy    (sq_busy),
    .done    (sq_done),
    .product (product)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    cnt_d    = cnt_q;
    sq_start = 1'b0;
    sq_abort = 1'b0;
    if (bus.clear && state_q != ST_DONE) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      sat_d    = 1'b0;
      cnt_d    = '0;
      sq_abort = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: if (rdy_q && bus.in_valid) begin
          sq_start = 1'b1;
          state_d  = ST_MUL;
        end
        ST_MUL: if (sq_done) state_d = ST_ACC;
        ST_ACC: begin
          acc_d   = add_r.sum[ACC_W-1:0];
          sat_d   = sat_q | add_r.sat;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_W'(FRAME_LEN)) ? ST_DONE : ST_IDLE;
        end
        ST_DONE: if (bus.out_ready) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // in_ready is registered so it stays low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == ST_IDLE);
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sse_out   = acc_q;
  assign bus.sse_sat   = sat_q;
endmodule

// File: tb/tb_fixed_point_sse_accumulator.sv
// Directed-vector bench: stimulus pushes expected frame results, a negedge monitor pops and compares.
module tb_fixed_point_sse_accumulator;
  localparam int Q = 8, N = 16, FL = 4, AW = 24;

  typedef struct {
    logic [AW-1:0] sse;
    logic          sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  fixed_point_sse_accumulator_if #(.N(N), .ACC_W(AW)) bus ();

  fixed_point_sse_accumulator #(.Q(Q), .N(N), .FRAME_LEN(FL), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got sse=%h sat=%0b with nothing expected",
                 bus.sse_out, bus.sse_sat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.sse_out !== e.sse || bus.sse_sat !== e.sat) begin
          failures++;
          $display("FAIL frame_result got sse=%h sat=%0b expected sse=%h sat=%0b",
                   bus.sse_out, bus.sse_sat, e.sse, e.sat);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [AW-1:0] sse, input logic sat);
    exp_t e;
    e.sse = sse;
    e.sat = sat;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [N-1:0] w);
    int t = 0;
    bus.diff_in  = w;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) chk("send_timeout", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!bus.out_valid && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic frame_done();
    wait_valid();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, acc_cnt, cyc;
    bus.diff_in = '0; bus.in_valid = 1'b0; bus.clear = 1'b0; bus.out_ready = 1'b1;

    // Reset state and in_ready rising one edge after release.
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sse_out",   64'(bus.sse_out),   64'd0);
    chk("rst_sse_sat",   64'(bus.sse_sat),   64'd0);
    rst = 1'b0;
    #1 chk("in_ready_before_edge", 64'(bus.in_ready), 64'd0);
    tick();
    chk("in_ready_after_edge", 64'(bus.in_ready), 64'd1);

    // 1.0^2 + 1.0^2 + 0.5^2 + 0 = 2.25
    push(24'h000240, 1'b0);
    send(16'h0100); send(16'hFF00); send(16'h0080); send(16'h0000);
    frame_done();

    // Most-negative input: each term 0x400000, fourth add overflows 24 bits.
    push(24'hFFFFFF, 1'b1);
    repeat (4) send(16'h8000);
    frame_done();

    // Held result: 4.0 + 4.0 + 1/256 + 0 (a 1-lsb square truncates away).
    bus.out_ready = 1'b0;
    push(24'h000801, 1'b0);
    send(16'h0200); send(16'hFE00); send(16'h0010); send(16'hFFFF);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_sse",       64'(bus.sse_out),   64'h801);
      chk("hold_in_ready",  64'(bus.in_ready),  64'd0);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      bus.in_valid = i[0];
      bus.diff_in  = 16'h7F00;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("release_out_valid", 64'(bus.out_valid), 64'd0);
    tick();

    // Clear during MUL of the third sample discards the partial frame.
    send(16'h0200); send(16'h0200); send(16'h0200);
    repeat (5) tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clear_in_ready", 64'(bus.in_ready), 64'd1);
    chk("clear_sse_out",  64'(bus.sse_out),  64'd0);
    push(24'h000400, 1'b0);
    repeat (4) send(16'h0100);
    frame_done();

    // Async reset mid-MUL of the second sample, then a fresh frame: 4 x 9.0.
    send(16'h0100); send(16'h0100);
    repeat (4) tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_sse_out",   64'(bus.sse_out),   64'd0);
    chk("arst_sse_sat",   64'(bus.sse_sat),   64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_recover_ready", 64'(bus.in_ready), 64'd1);
    push(24'h002400, 1'b0);
    repeat (4) send(16'h0300);
    frame_done();

    // Back-to-back in_valid: ready every N+2 cycles, FRAME_LEN accepts, valid N+2 after last.
    push(24'h000400, 1'b0);
    bus.diff_in  = 16'h0100;
    bus.in_valid = 1'b1;
    last = -1; acc_cnt = 0; cyc = 0;
    while (cyc < 300) begin
      if (bus.out_valid) begin
        chk("b2b_latency", 64'(cyc - last), 64'(N + 2));
        break;
      end
      if (bus.in_ready) begin
        if (last >= 0) chk("b2b_interval", 64'(cyc - last), 64'(N + 2));
        last = cyc;
        acc_cnt++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("b2b_accepts", 64'(acc_cnt), 64'(FL));
    repeat (3) tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
